// File: rtl/regfile_mp.sv
// Three-read / two-write register file with a post-reset init sequencer.
// Port 1 has write priority over port 0; same-cycle write data is optionally forwarded.
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int INIT_MODE = 1,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] reg_R_addr_A,
    input  logic [ADDR_W-1:0] reg_R_addr_B,
    input  logic [ADDR_W-1:0] reg_R_addr_C,
    input  logic [ADDR_W-1:0] reg_W_addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              reg_we0,
    input  logic [ADDR_W-1:0] reg_W_addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              reg_we1,
    output logic [DATA_W-1:0] rdata_A,
    output logic [DATA_W-1:0] rdata_B,
    output logic [DATA_W-1:0] rdata_C,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic                ready_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                init_we;
    logic [DATA_W-1:0]   init_val;
    logic                wr0, wr1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_INIT;
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            ready <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        ready_nxt = ready;
        case (state)
            S_INIT: begin
                ptr_nxt = ptr + ADDR_W'(1);
                if (ptr == '1) begin
                    state_nxt = S_RUN;
                    ready_nxt = 1'b1;
                end
            end
            S_RUN: ready_nxt = 1'b1;
        endcase
    end

    // Write qualification: init owns the array until S_RUN; writes to entry 0 vanish when hardwired.
    always_comb begin
        init_we  = rst && (state == S_INIT);
        init_val = (INIT_MODE != 0) ? DATA_W'(ptr) : '0;
        wr0 = rst && (state == S_RUN) && reg_we0 && !(ZERO_REG != 0 && reg_W_addr0 == '0);
        wr1 = rst && (state == S_RUN) && reg_we1 && !(ZERO_REG != 0 && reg_W_addr1 == '0);
    end

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[ptr] <= init_val;
        end else begin
            if (wr0) mem[reg_W_addr0] <= wdata0;
            if (wr1) mem[reg_W_addr1] <= wdata1;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a,
                                                     input logic [DATA_W-1:0] arr_v);
        logic [DATA_W-1:0] v;
        v = arr_v;
        if (BYPASS != 0 && wr0 && reg_W_addr0 == a) v = wdata0;
        if (BYPASS != 0 && wr1 && reg_W_addr1 == a) v = wdata1;
        if (ZERO_REG != 0 && a == '0) v = '0;
        if (!ready) v = '0;
        return v;
    endfunction

    always_comb begin
        rdata_A = read_port(reg_R_addr_A, mem[reg_R_addr_A]);
        rdata_B = read_port(reg_R_addr_B, mem[reg_R_addr_B]);
        rdata_C = read_port(reg_R_addr_C, mem[reg_R_addr_C]);
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the team's 3-read/1-write CPU register file.
- Adds a second write port with defined priority and optional same-cycle write-to-read bypass.
- Adds a post-reset initialisation sequencer that loads every entry one per cycle and asserts ready when done.
- Sits in the decode/writeback stage. Port 0 serves ALU writeback; port 1 serves load writeback.

Parameters:
DATA_W, 32, width of each register and of all data ports
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
INIT_MODE, 1, init value per entry: 0 = all zero, 1 = entry i loaded with i (zero-extended to DATA_W)
ZERO_REG, 1, 1 = entry 0 is hardwired to zero; 0 = entry 0 is an ordinary register
BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return the pre-edge value

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  reset, synchronous, active-low
reg_R_addr_A  in  ADDR_W  read address A
reg_R_addr_B  in  ADDR_W  read address B
reg_R_addr_C  in  ADDR_W  read address C
reg_W_addr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
reg_we0  in  1  write enable, port 0
reg_W_addr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
reg_we1  in  1  write enable, port 1
rdata_A  out  DATA_W  read data A (combinational)
rdata_B  out  DATA_W  read data B (combinational)
rdata_C  out  DATA_W  read data C (combinational)
ready  out  1  registered; 1 = initialisation complete, file usable

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-low, sampled only at the rising edge of clk.
- Reset: rst=0 at a posedge sets state=S_INIT, ptr=0, ready=0. Register contents are not cleared by reset itself; the INIT sequence clears them.
- FSM states: S_INIT and S_RUN.
- S_INIT:
  - Each posedge with rst=1 writes register[ptr] with init value (0, or ptr when INIT_MODE=1), then ptr increments.
  - The posedge that writes ptr=DEPTH-1 also sets state=S_RUN and ready=1.
  - INIT therefore takes exactly DEPTH cycles after reset release.
  - reg_we0 and reg_we1 are ignored throughout S_INIT.
- Reset mid-INIT: restarts at ptr=0 with ready=0. Reset in S_RUN returns to S_INIT.
- While ready=0: rdata_A/B/C are forced to 0.
- S_RUN writes:
  - Port k writes on posedge when reg_wek=1, unless ZERO_REG=1 and reg_W_addrk=0.
  - Both ports enabled with equal address: port 1 wins; port 0's data is discarded.
  - Different addresses: both writes commit on the same edge.
- S_RUN reads:
  - Reads are combinational from the array.
  - ZERO_REG=1 and address 0: read returns 0 regardless of writes or bypass.
  - BYPASS=1 and read address equals a qualifying write address (enable and zero-reg rule applied): return that port's wdata, port 1 before port 0. Otherwise return the array value.
  - BYPASS=0: return the array value; the new value is visible from the cycle after the edge.
- Width rules: INIT_MODE=1 value is ptr zero-extended to DATA_W, or truncated if ADDR_W > DATA_W. No other arithmetic.
- All three read ports are independent. Any combination of equal read addresses is legal.

Test Plan:
1. Reset then INIT: hold rst=0 for 2 cycles, release. Required: ready=0 and rdata_A=0 for 31 posedges; ready=1 after the 32nd posedge. Then read addr 7 -> 7, addr 31 -> 31, addr 0 -> 0 (INIT_MODE=1).
2. Dual write, different addresses: we0 addr 3 data 0xAAAA0003, we1 addr 4 data 0x55550004 on the same edge. Required: next cycle addr 3 reads 0xAAAA0003 and addr 4 reads 0x55550004.
3. Collision: both ports write addr 9, port0 data 0x11111111, port1 data 0x22222222. Required: bypass read in that cycle = 0x22222222; after the edge addr 9 = 0x22222222.
4. Zero register: we0 addr 0 data 0xDEADBEEF with read A addr 0. Required: rdata_A=0 in the same cycle and after the edge. With ZERO_REG=0, the same write gives 0xDEADBEEF after the edge.
5. Bypass off (BYPASS=0): write addr 5 data 0x12345678 while reading addr 5. Required: read shows 5 in that cycle and 0x12345678 the next cycle.
6. Reset mid-INIT: drive rst=0 after 10 INIT cycles, then release. Required: ready stays 0 for a further 32 cycles. Writes issued during INIT are dropped, e.g. we0 addr 2 data 0xFF ignored, so addr 2 reads 2 after ready.
